// File: rtl/oddr_tx_ctrl.sv
// oddr_tx_ctrl: sequences a single ODDR output. Owns the ODDR reset
// (hold, then settle), accepts words over valid/ready into a one-entry
// buffer and shifts them out two bits per clock, LSB first, on D1/D2.
module oddr_tx_ctrl #(
   parameter int unsigned DATA_W        = 8,
   parameter int unsigned RST_CYCLES    = 4,
   parameter int unsigned SETTLE_CYCLES = 3,
   parameter logic        IDLE_D1       = 1'b0,
   parameter logic        IDLE_D2       = 1'b0
) (
   input  logic              C,
   input  logic              R,
   input  logic              i_restart,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              o_d1,
   output logic              o_d2,
   output logic              o_oddr_rst,
   output logic              o_busy,
   output logic              o_frame_done,
   output logic              o_underrun
);

   localparam int unsigned BEATS   = DATA_W / 2;
   localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [1:0] ST_HOLD   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_IDLE   = 2'd2;
   localparam logic [1:0] ST_SHIFT  = 2'd3;

   localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BEATS - 1);
   localparam logic [CNT_W-1:0]  RST_INIT    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]  SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] buf_data;
   logic              buf_last;
   logic              buf_v;
   logic [DATA_W-1:0] sh;
   logic              cur_last;
   logic [BEAT_W-1:0] beat;

   // Buffer is open only once the ODDR is out of reset and the slot is empty.
   always_comb begin
      s_ready = ((state == ST_IDLE) || (state == ST_SHIFT)) && !buf_v;
   end

   // Reset sequencing, input buffering and bit-pair serialization.
   always_ff @(posedge C or posedge R) begin
      if (R) begin
         state        <= ST_HOLD;
         cnt          <= RST_INIT;
         o_oddr_rst   <= 1'b1;
         o_d1         <= IDLE_D1;
         o_d2         <= IDLE_D2;
         o_busy       <= 1'b0;
         o_frame_done <= 1'b0;
         o_underrun   <= 1'b0;
         buf_v        <= 1'b0;
         buf_data     <= '0;
         buf_last     <= 1'b0;
         sh           <= '0;
         cur_last     <= 1'b0;
         beat         <= '0;
      end else if (i_restart) begin
         // Restart drops any word in flight; the underrun flag survives.
         state        <= ST_HOLD;
         cnt          <= RST_INIT;
         o_oddr_rst   <= 1'b1;
         o_d1         <= IDLE_D1;
         o_d2         <= IDLE_D2;
         o_busy       <= 1'b0;
         o_frame_done <= 1'b0;
         buf_v        <= 1'b0;
         sh           <= '0;
      end else begin
         o_frame_done <= 1'b0;

         // Acceptance needs an empty buffer and draining needs a full one,
         // so these never collide on buf_v within one edge.
         if (s_valid && s_ready) begin
            buf_data <= s_data;
            buf_last <= s_last;
            buf_v    <= 1'b1;
         end

         case (state)
            ST_HOLD: begin
               if (cnt == '0) begin
                  state      <= ST_SETTLE;
                  cnt        <= SETTLE_INIT;
                  o_oddr_rst <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            ST_SETTLE: begin
               if (cnt == '0) begin
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            ST_IDLE: begin
               if (buf_v) begin
                  o_d1     <= buf_data[0];
                  o_d2     <= buf_data[1];
                  sh       <= buf_data >> 2;
                  cur_last <= buf_last;
                  buf_v    <= 1'b0;
                  beat     <= '0;
                  state    <= ST_SHIFT;
                  o_busy   <= 1'b1;
               end
            end

            ST_SHIFT: begin
               if (beat != LAST_BEAT) begin
                  o_d1 <= sh[0];
                  o_d2 <= sh[1];
                  sh   <= sh >> 2;
                  beat <= beat + BEAT_W'(1);
               end else begin
                  o_frame_done <= cur_last;
                  if (buf_v) begin
                     o_d1     <= buf_data[0];
                     o_d2     <= buf_data[1];
                     sh       <= buf_data >> 2;
                     cur_last <= buf_last;
                     buf_v    <= 1'b0;
                     beat     <= '0;
                     o_busy   <= 1'b1;
                  end else begin
                     o_d1   <= IDLE_D1;
                     o_d2   <= IDLE_D2;
                     state  <= ST_IDLE;
                     o_busy <= 1'b0;
                     if (!cur_last) begin
                        o_underrun <= 1'b1;
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_oddr_tx_ctrl.sv
// tb_oddr_tx_ctrl: scoreboard bench. Accepted words are queued with their
// acceptance edge; a negedge monitor derives, per cycle, which word and bit
// pair should be on the pins and compares every output against that.
module tb_oddr_tx_ctrl;

   localparam int DATA_W        = 8;
   localparam int RST_CYCLES    = 4;
   localparam int SETTLE_CYCLES = 3;
   localparam int H             = DATA_W / 2;

   logic              C = 1'b0;
   logic              R = 1'b1;
   logic              i_restart = 1'b0;
   logic [DATA_W-1:0] s_data = '0;
   logic              s_last = 1'b0;
   logic              s_valid = 1'b0;
   logic              s_ready, o_d1, o_d2, o_oddr_rst, o_busy, o_frame_done, o_underrun;

   oddr_tx_ctrl #(
      .DATA_W       (DATA_W),
      .RST_CYCLES   (RST_CYCLES),
      .SETTLE_CYCLES(SETTLE_CYCLES),
      .IDLE_D1      (1'b0),
      .IDLE_D2      (1'b0)
   ) dut (
      .C           (C),
      .R           (R),
      .i_restart   (i_restart),
      .s_data      (s_data),
      .s_last      (s_last),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .o_d1        (o_d1),
      .o_d2        (o_d2),
      .o_oddr_rst  (o_oddr_rst),
      .o_busy      (o_busy),
      .o_frame_done(o_frame_done),
      .o_underrun  (o_underrun)
   );

   always #5 C = ~C;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Edge counter: after the n-th rising edge, cyc == n.
   always @(posedge C) cyc <= cyc + 1;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              last;
      int                acc;
   } word_t;

   word_t q[$];

   // Reference model state
   bit                have_cur  = 1'b0;
   logic [DATA_W-1:0] cur_data  = '0;
   bit                cur_last  = 1'b0;
   int                cur_s     = 0;
   int                prev_end  = -100;
   bit                prev_last = 1'b0;
   bit                und_exp   = 1'b0;
   int                base      = -100;
   bit                rst_req   = 1'b0;
   int                rs_edge   = -1;
   bit                model_on  = 1'b0;

   task automatic chk(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b (edge %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: advance the model for this cycle, compare, then log handshakes.
   always @(negedge C) begin
      int    e, st, k;
      logic  x1, x2;
      word_t w;
      e = cyc;
      if (rst_req) begin
         rst_req  = 1'b0;
         q.delete();
         have_cur = 1'b0;
         prev_end = -100;
         und_exp  = 1'b0;
         base     = e;
         model_on = 1'b1;
      end
      if (e == rs_edge) begin
         q.delete();
         have_cur = 1'b0;
         prev_end = -100;
         base     = e;
      end
      if (model_on && !R) begin
         if (have_cur && e == cur_s + H) begin
            have_cur  = 1'b0;
            prev_end  = e;
            prev_last = cur_last;
         end
         if (!have_cur && q.size() > 0) begin
            st = q[0].acc + 1;
            if (prev_end > st) st = prev_end;
            if (st <= e) begin
               w        = q.pop_front();
               cur_data = w.data;
               cur_last = w.last;
               cur_s    = e;
               have_cur = 1'b1;
            end
         end
         if (e == prev_end && !prev_last && !(have_cur && cur_s == e)) und_exp = 1'b1;
         if (have_cur) begin
            k  = e - cur_s;
            x1 = cur_data[2*k];
            x2 = cur_data[2*k+1];
         end else begin
            x1 = 1'b0;
            x2 = 1'b0;
         end
         chk("d1", o_d1, x1);
         chk("d2", o_d2, x2);
         chk("busy", o_busy, have_cur);
         chk("frame_done", o_frame_done, (e == prev_end) && prev_last);
         chk("underrun", o_underrun, und_exp);
         chk("oddr_rst", o_oddr_rst, e < base + RST_CYCLES);
         if (e < base + RST_CYCLES + SETTLE_CYCLES)
            chk("ready_low", s_ready, 1'b0);
         else if (e == base + RST_CYCLES + SETTLE_CYCLES)
            chk("ready_rise", s_ready, 1'b1);

         if (i_restart) rs_edge = e + 1;
         else if (s_valid && s_ready) q.push_back('{s_data, s_last, e + 1});
      end
   end

   task automatic step();
      @(posedge C);
      #1;
   endtask

   task automatic send(input logic [DATA_W-1:0] d, input logic l);
      int n;
      bit got;
      s_data  = d;
      s_last  = l;
      s_valid = 1'b1;
      n       = 0;
      got     = 1'b0;
      while (!got && n < 60) begin
         @(negedge C);
         got = s_ready;
         step();
         n++;
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got no ready want ready within 60 cycles (edge %0d)", cyc);
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (s_ready !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      total++;
      if (s_ready !== 1'b1) begin
         bad++;
         $display("FAIL ready_timeout: got %b want 1 within 40 cycles", s_ready);
      end
   endtask

   initial begin
      #100000;
      bad++;
      $display("FAIL watchdog: got no finish want finish before time limit");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset release with a source that is already valid.
      s_valid = 1'b1;
      s_data  = DATA_W'($urandom);
      s_last  = 1'b1;
      repeat (3) @(posedge C);
      #2;
      R       = 1'b0;
      rst_req = 1'b1;
      step();
      send(s_data, 1'b1);
      s_valid = 1'b0;
      repeat (6) step();

      // Single word
      send(8'hB4, 1'b1);
      s_valid = 1'b0;
      repeat (7) step();

      // Back-to-back frame, source always valid
      send(8'hFF, 1'b0);
      send(8'h00, 1'b1);
      s_valid = 1'b0;
      repeat (10) step();

      // Underrun: non-last word, then starve
      send(8'hAA, 1'b0);
      s_valid = 1'b0;
      repeat (8) step();
      chk("underrun_sticky", o_underrun, 1'b1);

      // Restart during beat 2
      send(8'h5A, 1'b1);
      s_valid = 1'b0;
      step();
      step();
      i_restart = 1'b1;
      step();
      i_restart = 1'b0;
      chk("rs_oddr_rst", o_oddr_rst, 1'b1);
      chk("rs_ready", s_ready, 1'b0);
      chk("rs_busy", o_busy, 1'b0);
      chk("rs_d1", o_d1, 1'b0);
      chk("rs_underrun_kept", o_underrun, 1'b1);
      wait_ready();
      send(8'h96, 1'b1);
      s_valid = 1'b0;
      repeat (7) step();

      // Async reset while shifting with a word buffered
      send(8'h3C, 1'b0);
      send(8'hC3, 1'b1);
      #1;
      R = 1'b1;
      #1;
      chk("ar_oddr_rst", o_oddr_rst, 1'b1);
      chk("ar_d1", o_d1, 1'b0);
      chk("ar_d2", o_d2, 1'b0);
      chk("ar_busy", o_busy, 1'b0);
      chk("ar_frame_done", o_frame_done, 1'b0);
      chk("ar_underrun", o_underrun, 1'b0);
      chk("ar_ready", s_ready, 1'b0);
      s_valid = 1'b0;
      #1;
      R       = 1'b0;
      rst_req = 1'b1;
      wait_ready();
      send(8'h71, 1'b1);
      s_valid = 1'b0;
      repeat (7) step();

      // Randomized traffic with occasional restarts
      for (int i = 0; i < 400; i++) begin
         s_valid   = ($urandom % 4) != 0;
         s_data    = DATA_W'($urandom);
         s_last    = ($urandom % 3) == 0;
         i_restart = ($urandom % 150) == 0;
         step();
      end
      i_restart = 1'b0;
      s_valid   = 1'b0;
      repeat (15) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
